// File: rtl/simplecpu_uart_loader.sv
// simplecpu_uart_loader
//   Receives a framed program image over an 8N1 UART line and writes it into the
//   simplecpu RAM through the load_ram/load_addr/load_data port. The core is held
//   in reset (cpu_reset=0) while loading. It is released only after the image
//   checksum matches.
//   Frame: SYNC_BYTE, 16 data bytes (addr 0..15), csum = sum of data mod 256.
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   rx         UART serial input (idle high, asynchronous to clk)
//   load_ram   one-cycle RAM write strobe
//   load_addr  RAM write address (holds when load_ram=0)
//   load_data  RAM write data (holds when load_ram=0)
//   cpu_reset  active-low core reset; 0 while loading or after a failed load
//   load_busy  1 from sync byte until the checksum is judged or the frame aborts
//   load_err   sticky error (checksum, framing, timeout); cleared by the next sync
module simplecpu_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [19:0] TIMEOUT_CLKS = 20'd65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       load_ram,
  output logic [3:0] load_addr,
  output logic [7:0] load_data,
  output logic       cpu_reset,
  output logic       load_busy,
  output logic       load_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;
  typedef enum logic [1:0] {L_IDLE, L_DATA, L_CSUM, L_RUN}   lstate_t;

  rstate_t          rstate, rstate_nx;
  lstate_t          lstate, lstate_nx;

  logic             rx_p0, rx_p1, rx_p2;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             frame_err;

  logic [3:0]       addr;
  logic [7:0]       sum;
  logic [19:0]      tmo;
  logic             is_sync;
  logic             abort;

  // ---- receiver: 2-flop synchronizer (rx_p0, rx_p1), rx_p2 is the previous
  //      synchronized level for falling-edge detection
  always_comb begin
    rstate_nx = rstate;
    case (rstate)
      R_IDLE:  if (rx_p2 && !rx_p1) rstate_nx = R_START;
      R_START: if (cnt == HALF_LAST) rstate_nx = rx_p1 ? R_IDLE : R_DATA;
      R_DATA:  if (cnt == BIT_LAST && bit_idx == 3'd7) rstate_nx = R_STOP;
      R_STOP:  if (cnt == BIT_LAST) rstate_nx = R_IDLE;
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rstate <= R_IDLE;
    else        rstate <= rstate_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      rx_p2      <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_p0      <= rx;
      rx_p1      <= rx_p0;
      rx_p2      <= rx_p1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rstate)
        R_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        R_START: cnt <= (cnt == HALF_LAST) ? '0 : cnt + 1'b1;
        R_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_p1, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            rx_byte    <= shift;
            byte_valid <= rx_p1;
            frame_err  <= !rx_p1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // ---- loader: frame sequencing, RAM writes, checksum judgement
  assign is_sync = (rx_byte == SYNC_BYTE);
  // Timeout counts clocks since the last accepted byte; abort once TIMEOUT_CLKS pass.
  assign abort   = frame_err || (!byte_valid && (tmo >= TIMEOUT_CLKS - 20'd1));

  always_comb begin
    lstate_nx = lstate;
    case (lstate)
      L_IDLE, L_RUN: if (byte_valid && is_sync) lstate_nx = L_DATA;
      L_DATA: begin
        if (abort)                             lstate_nx = L_IDLE;
        else if (byte_valid && addr == 4'hF)   lstate_nx = L_CSUM;
      end
      L_CSUM: begin
        if (abort)           lstate_nx = L_IDLE;
        else if (byte_valid) lstate_nx = (rx_byte == sum) ? L_RUN : L_IDLE;
      end
      default: lstate_nx = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lstate <= L_IDLE;
    else        lstate <= lstate_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_ram  <= 1'b0;
      load_addr <= '0;
      load_data <= '0;
      cpu_reset <= 1'b0;
      load_busy <= 1'b0;
      load_err  <= 1'b0;
      addr      <= '0;
      sum       <= '0;
      tmo       <= '0;
    end else begin
      load_ram <= 1'b0;
      case (lstate)
        L_IDLE, L_RUN: begin
          // A sync byte (re)starts a load; the core goes back into reset at once.
          if (byte_valid && is_sync) begin
            cpu_reset <= 1'b0;
            load_busy <= 1'b1;
            load_err  <= 1'b0;
            addr      <= '0;
            sum       <= '0;
            tmo       <= '0;
          end
        end
        L_DATA, L_CSUM: begin
          if (abort) begin
            load_err  <= 1'b1;
            load_busy <= 1'b0;
            cpu_reset <= 1'b0;
          end else if (byte_valid) begin
            tmo <= '0;
            if (lstate == L_DATA) begin
              load_ram  <= 1'b1;
              load_addr <= addr;
              load_data <= rx_byte;
              sum       <= sum + rx_byte;
              addr      <= addr + 4'd1;
            end else begin
              load_busy <= 1'b0;
              if (rx_byte == sum) cpu_reset <= 1'b1;
              else                load_err  <= 1'b1;
            end
          end else begin
            tmo <= tmo + 20'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simplecpu_uart_loader.sv
module tb_simplecpu_uart_loader;

  localparam int unsigned CPB  = 4;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       load_ram;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       cpu_reset;
  logic       load_busy;
  logic       load_err;

  simplecpu_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CLKS(20'd200)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .load_ram (load_ram),
    .load_addr(load_addr),
    .load_data(load_data),
    .cpu_reset(cpu_reset),
    .load_busy(load_busy),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level reference model of the loader.
  bit          m_loading, m_run, m_err;
  int          m_cnt;
  logic [7:0]  m_sum;
  logic [11:0] exp_wr[$];
  logic [11:0] got_wr[$];
  int          inv_bad = 0;
  int          hold_bad = 0;
  logic [3:0]  last_a;
  logic [7:0]  last_d;
  logic [7:0]  fr [16];

  task automatic model_reset();
    m_loading = 0; m_run = 0; m_err = 0; m_cnt = 0; m_sum = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      if (m_loading) begin m_err = 1; m_loading = 0; end
    end else if (!m_loading) begin
      if (b == SYNC) begin m_loading = 1; m_cnt = 0; m_sum = 0; m_err = 0; m_run = 0; end
    end else if (m_cnt < 16) begin
      exp_wr.push_back({4'(m_cnt), b});
      m_sum = m_sum + b;
      m_cnt++;
    end else begin
      if (b == m_sum) m_run = 1; else m_err = 1;
      m_loading = 0;
    end
  endtask

  task automatic model_timeout();
    if (m_loading) begin m_err = 1; m_loading = 0; end
  endtask

  // Write monitor: records every strobe, flags writes outside core reset and
  // address/data changes while no strobe is present.
  always @(negedge clk) begin
    if (!reset) begin
      last_a = '0; last_d = '0;
    end else if (load_ram) begin
      got_wr.push_back({load_addr, load_data});
      if (cpu_reset !== 1'b0) inv_bad++;
      last_a = load_addr; last_d = load_data;
    end else if (load_addr !== last_a || load_data !== last_d) begin
      hold_bad++;
      last_a = load_addr; last_d = load_data;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    int g;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    g = (gap < 0) ? int'($urandom_range(1, 3)) : gap;
    repeat (CPB * g) @(negedge clk);
    model_byte(b, stop_ok);
  endtask

  task automatic send_frame(input bit with_sync, input int n, input logic [7:0] cs);
    if (with_sync) send_byte(SYNC, 1'b1, -1);
    for (int i = 0; i < n; i++) send_byte(fr[i], 1'b1, -1);
    if (n == 16) send_byte(cs, 1'b1, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0; rx = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (load_ram  !== 1'b0) begin n_bad++; $display("FAIL rst_load_ram: got %b want 0", load_ram); end
    n_cmp++; if (load_addr !== 4'h0) begin n_bad++; $display("FAIL rst_load_addr: got %h want 0", load_addr); end
    n_cmp++; if (load_data !== 8'h0) begin n_bad++; $display("FAIL rst_load_data: got %h want 0", load_data); end
    n_cmp++; if (cpu_reset !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_reset: got %b want 0", cpu_reset); end
    n_cmp++; if (load_busy !== 1'b0) begin n_bad++; $display("FAIL rst_load_busy: got %b want 0", load_busy); end
    n_cmp++; if (load_err  !== 1'b0) begin n_bad++; $display("FAIL rst_load_err: got %b want 0", load_err); end
    reset = 1'b1;
    repeat (CPB * 2) @(negedge clk);
  endtask

  // Shared wrap-up pattern written out per scenario.
  task automatic test_good_load();
    int lat;
    for (int i = 0; i < 16; i++) fr[i] = 8'(i);
    send_frame(1'b1, 16, 8'h78);
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_reset === 1'b1) begin lat = i; break; end
    end
    n_cmp++; if (lat < 0 || lat > 3) begin n_bad++; $display("FAIL good_release_latency: got %0d want 0..3", lat); end
    n_cmp++; if (load_err !== m_err) begin n_bad++; $display("FAIL good_err: got %b want %b", load_err, m_err); end
    n_cmp++; if (load_busy !== m_loading) begin n_bad++; $display("FAIL good_busy: got %b want %b", load_busy, m_loading); end
    n_cmp++; if (got_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL good_nwrites: got %0d want %0d", got_wr.size(), exp_wr.size()); end
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      n_cmp++; if (got_wr[i] !== exp_wr[i]) begin n_bad++; $display("FAIL good_write%0d: got %h want %h", i, got_wr[i], exp_wr[i]); end
    end
    got_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_reload();
    int lat;
    send_byte(SYNC, 1'b1, 0);
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_reset === 1'b0) begin lat = i; break; end
    end
    n_cmp++; if (lat < 0 || lat > 3) begin n_bad++; $display("FAIL reload_hold_latency: got %0d want 0..3", lat); end
    n_cmp++; if (load_busy !== 1'b1) begin n_bad++; $display("FAIL reload_busy: got %b want 1", load_busy); end
    for (int i = 0; i < 16; i++) fr[i] = 8'hFF;
    send_frame(1'b0, 16, 8'hF0);
    repeat (8) @(negedge clk);
    n_cmp++; if (cpu_reset !== m_run) begin n_bad++; $display("FAIL reload_cpu_reset: got %b want %b", cpu_reset, m_run); end
    n_cmp++; if (load_err !== m_err) begin n_bad++; $display("FAIL reload_err: got %b want %b", load_err, m_err); end
    n_cmp++; if (got_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL reload_nwrites: got %0d want %0d", got_wr.size(), exp_wr.size()); end
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      n_cmp++; if (got_wr[i] !== exp_wr[i]) begin n_bad++; $display("FAIL reload_write%0d: got %h want %h", i, got_wr[i], exp_wr[i]); end
    end
    got_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_bad_csum();
    for (int i = 0; i < 16; i++) fr[i] = 8'(i);
    send_frame(1'b1, 16, 8'h77);
    repeat (8) @(negedge clk);
    n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL badcs_err: got %b want 1", load_err); end
    n_cmp++; if (cpu_reset !== m_run) begin n_bad++; $display("FAIL badcs_cpu_reset: got %b want %b", cpu_reset, m_run); end
    n_cmp++; if (load_busy !== m_loading) begin n_bad++; $display("FAIL badcs_busy: got %b want %b", load_busy, m_loading); end
    n_cmp++; if (got_wr.size() != 16) begin n_bad++; $display("FAIL badcs_nwrites: got %0d want 16", got_wr.size()); end
    got_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_idle_junk();
    logic [7:0] cs;
    send_byte(8'h3C, 1'b1, -1);
    send_byte(8'hFF, 1'b1, -1);
    repeat (4) @(negedge clk);
    n_cmp++; if (got_wr.size() != 0) begin n_bad++; $display("FAIL junk_nwrites: got %0d want 0", got_wr.size()); end
    n_cmp++; if (load_busy !== 1'b0) begin n_bad++; $display("FAIL junk_busy: got %b want 0", load_busy); end
    cs = 8'h00;
    for (int i = 0; i < 16; i++) begin fr[i] = 8'($urandom); cs = cs + fr[i]; end
    send_frame(1'b1, 16, cs);
    repeat (8) @(negedge clk);
    n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL junk_release: got %b want 1", cpu_reset); end
    n_cmp++; if (got_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL junk_frame_nwrites: got %0d want %0d", got_wr.size(), exp_wr.size()); end
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      n_cmp++; if (got_wr[i] !== exp_wr[i]) begin n_bad++; $display("FAIL junk_write%0d: got %h want %h", i, got_wr[i], exp_wr[i]); end
    end
    got_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_frame_err();
    logic [7:0] cs;
    for (int i = 0; i < 5; i++) fr[i] = 8'(i);
    send_frame(1'b1, 5, 8'h00);
    send_byte(8'h05, 1'b0, 3);
    repeat (4) @(negedge clk);
    n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL ferr_err: got %b want 1", load_err); end
    n_cmp++; if (load_busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy: got %b want 0", load_busy); end
    n_cmp++; if (cpu_reset !== 1'b0) begin n_bad++; $display("FAIL ferr_cpu_reset: got %b want 0", cpu_reset); end
    n_cmp++; if (got_wr.size() != 5) begin n_bad++; $display("FAIL ferr_nwrites: got %0d want 5", got_wr.size()); end
    got_wr.delete(); exp_wr.delete();
    cs = 8'h00;
    for (int i = 0; i < 16; i++) begin fr[i] = 8'($urandom); cs = cs + fr[i]; end
    send_frame(1'b1, 16, cs);
    repeat (8) @(negedge clk);
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL ferr_recover_err: got %b want 0", load_err); end
    n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL ferr_recover_release: got %b want 1", cpu_reset); end
    got_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] cs;
    for (int i = 0; i < 8; i++) fr[i] = 8'($urandom);
    send_frame(1'b1, 8, 8'h00);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if ({load_ram, load_addr, load_data, cpu_reset, load_busy, load_err} !== 16'h0)
      begin n_bad++; $display("FAIL midrst_outputs: got %h want 0", {load_ram, load_addr, load_data, cpu_reset, load_busy, load_err}); end
    reset = 1'b1;
    got_wr.delete(); exp_wr.delete();
    repeat (CPB * 2) @(negedge clk);
    cs = 8'h00;
    for (int i = 0; i < 16; i++) begin fr[i] = 8'($urandom); cs = cs + fr[i]; end
    send_frame(1'b1, 16, cs);
    repeat (8) @(negedge clk);
    n_cmp++; if (cpu_reset !== m_run) begin n_bad++; $display("FAIL midrst_release: got %b want %b", cpu_reset, m_run); end
    n_cmp++; if (got_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL midrst_nwrites: got %0d want %0d", got_wr.size(), exp_wr.size()); end
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      n_cmp++; if (got_wr[i] !== exp_wr[i]) begin n_bad++; $display("FAIL midrst_write%0d: got %h want %h", i, got_wr[i], exp_wr[i]); end
    end
    got_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_stall();
    logic [7:0] cs;
    for (int i = 0; i < 8; i++) fr[i] = 8'($urandom);
    send_frame(1'b1, 8, 8'h00);
    repeat (250) @(negedge clk);
    model_timeout();
    n_cmp++; if (load_err !== m_err) begin n_bad++; $display("FAIL stall_err: got %b want %b", load_err, m_err); end
    n_cmp++; if (load_busy !== m_loading) begin n_bad++; $display("FAIL stall_busy: got %b want %b", load_busy, m_loading); end
    n_cmp++; if (cpu_reset !== 1'b0) begin n_bad++; $display("FAIL stall_cpu_reset: got %b want 0", cpu_reset); end
    n_cmp++; if (got_wr.size() != 8) begin n_bad++; $display("FAIL stall_nwrites: got %0d want 8", got_wr.size()); end
    got_wr.delete(); exp_wr.delete();
    cs = 8'h00;
    for (int i = 0; i < 16; i++) begin fr[i] = 8'($urandom); cs = cs + fr[i]; end
    send_frame(1'b1, 16, cs);
    repeat (8) @(negedge clk);
    n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL stall_recover: got %b want 1", cpu_reset); end
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL stall_recover_err: got %b want 0", load_err); end
    got_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_random();
    logic [7:0] cs;
    logic [7:0] junk;
    for (int f = 0; f < 4; f++) begin
      junk = 8'($urandom_range(0, 254));
      if (junk == SYNC) junk = 8'h5A;
      send_byte(junk, 1'b1, -1);
      cs = 8'h00;
      for (int i = 0; i < 16; i++) begin
        fr[i] = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
        cs = cs + fr[i];
      end
      if ($urandom_range(0, 1) == 1) cs = cs + 8'($urandom_range(1, 255));
      send_frame(1'b1, 16, cs);
      repeat (8) @(negedge clk);
      n_cmp++; if (cpu_reset !== m_run) begin n_bad++; $display("FAIL rnd%0d_cpu_reset: got %b want %b", f, cpu_reset, m_run); end
      n_cmp++; if (load_err !== m_err) begin n_bad++; $display("FAIL rnd%0d_err: got %b want %b", f, load_err, m_err); end
      n_cmp++; if (load_busy !== m_loading) begin n_bad++; $display("FAIL rnd%0d_busy: got %b want %b", f, load_busy, m_loading); end
      n_cmp++; if (got_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL rnd%0d_nwrites: got %0d want %0d", f, got_wr.size(), exp_wr.size()); end
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
        n_cmp++; if (got_wr[i] !== exp_wr[i]) begin n_bad++; $display("FAIL rnd%0d_write%0d: got %h want %h", f, i, got_wr[i], exp_wr[i]); end
      end
      got_wr.delete(); exp_wr.delete();
    end
  endtask

  task automatic test_invariants();
    n_cmp++; if (inv_bad != 0) begin n_bad++; $display("FAIL write_outside_reset: got %0d want 0", inv_bad); end
    n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL addr_data_hold: got %0d want 0", hold_bad); end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_reload();
    test_bad_csum();
    test_idle_junk();
    test_frame_err();
    test_reset_mid();
    test_stall();
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
